// File: rtl/global_stats_reader.sv
// Read-side of the global statistics counters: snapshots all four 64-bit counters
// on a request and streams the selected one(s) out as DATA_W-bit words over valid/ready.
// Optional macro STATS_CLEAR_ON_READ_EN: pulse stats_clear once after each legal accept.
module global_stats_reader #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       wait_for_insn_fetch,
    input  logic [63:0]       num_cycles_used,
    input  logic [63:0]       wait_for_operand_fetch,
    input  logic [63:0]       num_vector_local_divergences,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [1:0]        rsp_idx,
    output logic              rsp_last,
    output logic              rsp_err,
    output logic              busy,
    output logic              stats_clear
);

    localparam int WORDS_PER_CTR = 64 / DATA_W;
    localparam int WORD_W        = (WORDS_PER_CTR > 1) ? $clog2(WORDS_PER_CTR) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(WORDS_PER_CTR - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            r_state, w_state_next;
    logic [63:0]       w_ctr  [4];
    logic [63:0]       r_snap [4];
    logic [63:0]       w_snap_sel;
    logic [1:0]        r_cur_idx, w_cur_idx_next;
    logic [WORD_W-1:0] r_word, w_word_next;
    logic              r_all, w_all_next;
    logic              w_capture;
    logic              w_final;

    assign w_ctr[0] = wait_for_insn_fetch;
    assign w_ctr[1] = num_cycles_used;
    assign w_ctr[2] = wait_for_operand_fetch;
    assign w_ctr[3] = num_vector_local_divergences;

    assign w_snap_sel = r_snap[r_cur_idx];
    // Final word: last word of the single counter, or of counter 3 when dumping all.
    assign w_final    = (r_word == LAST_WORD) && (!r_all || (r_cur_idx == 2'd3));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cur_idx <= 2'd0;
            r_word    <= '0;
            r_all     <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_snap[i] <= '0;
            end
        end else begin
            r_state   <= w_state_next;
            r_cur_idx <= w_cur_idx_next;
            r_word    <= w_word_next;
            r_all     <= w_all_next;
            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    r_snap[i] <= w_ctr[i];
                end
            end
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cur_idx_next = r_cur_idx;
        w_word_next    = r_word;
        w_all_next     = r_all;
        w_capture      = 1'b0;
        req_ready      = 1'b0;
        rsp_valid      = 1'b0;
        rsp_data       = '0;
        rsp_idx        = 2'd0;
        rsp_last       = 1'b0;
        rsp_err        = 1'b0;
        busy           = 1'b1;

        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    if (req_sel <= 3'd4) begin
                        w_capture      = 1'b1;
                        w_state_next   = SEND;
                        w_all_next     = (req_sel == 3'd4);
                        w_cur_idx_next = (req_sel == 3'd4) ? 2'd0 : req_sel[1:0];
                        w_word_next    = '0;
                    end else begin
                        w_state_next = ERR;
                    end
                end
            end
            SEND: begin
                rsp_valid = 1'b1;
                rsp_data  = w_snap_sel[r_word*DATA_W +: DATA_W];
                rsp_idx   = r_cur_idx;
                rsp_last  = w_final;
                if (rsp_ready) begin
                    if (w_final) begin
                        w_state_next = IDLE;
                    end else if (r_word == LAST_WORD) begin
                        w_word_next    = '0;
                        w_cur_idx_next = r_cur_idx + 2'd1;
                    end else begin
                        w_word_next = r_word + 1'b1;
                    end
                end
            end
            ERR: begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
                rsp_last  = 1'b1;
                if (rsp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

`ifdef STATS_CLEAR_ON_READ_EN
    logic r_stats_clear;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stats_clear <= 1'b0;
        end else begin
            r_stats_clear <= w_capture;
        end
    end

    assign stats_clear = r_stats_clear;
`else
    assign stats_clear = 1'b0;
`endif

endmodule

// File: tb/tb_global_stats_reader.sv
// Directed bench for global_stats_reader: a queue-based reference model built at
// accept time is compared with the DUT every cycle, plus literal checks per scenario.
module tb_global_stats_reader;

    localparam int DW  = 32;
    localparam int WPC = 64 / DW;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    idx;
        logic          last;
        logic          err;
    } word_t;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [63:0]   ctr [4];
    logic          req_valid;
    logic          req_ready;
    logic [2:0]    req_sel;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic [1:0]    rsp_idx;
    logic          rsp_last;
    logic          rsp_err;
    logic          busy;
    logic          stats_clear;

    int    checks   = 0;
    int    failures = 0;
    logic  chk_en   = 1'b0;
    word_t exp_q[$];
    word_t got_q[$];
    logic  exp_clear = 1'b0;

    global_stats_reader #(.DATA_W(DW)) dut (
        .clk                          (clk),
        .reset_n                      (reset_n),
        .wait_for_insn_fetch          (ctr[0]),
        .num_cycles_used              (ctr[1]),
        .wait_for_operand_fetch       (ctr[2]),
        .num_vector_local_divergences (ctr[3]),
        .req_valid                    (req_valid),
        .req_ready                    (req_ready),
        .req_sel                      (req_sel),
        .rsp_valid                    (rsp_valid),
        .rsp_ready                    (rsp_ready),
        .rsp_data                     (rsp_data),
        .rsp_idx                      (rsp_idx),
        .rsp_last                     (rsp_last),
        .rsp_err                      (rsp_err),
        .busy                         (busy),
        .stats_clear                  (stats_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the whole response is enqueued from the counter values at the accept edge.
    always @(posedge clk) begin
        if (!reset_n) begin
            exp_q.delete();
            exp_clear <= 1'b0;
        end else if (exp_q.size() != 0) begin
            exp_clear <= 1'b0;
            if (rsp_ready) void'(exp_q.pop_front());
        end else begin
            exp_clear <= 1'b0;
            if (req_valid) begin
                if (req_sel <= 3'd4) begin
                    int lo;
                    int hi;
                    word_t item;
                    lo = (req_sel == 3'd4) ? 0 : int'(req_sel);
                    hi = (req_sel == 3'd4) ? 3 : int'(req_sel);
                    for (int c = lo; c <= hi; c++) begin
                        for (int w = 0; w < WPC; w++) begin
                            item.data = DW'(ctr[c] >> (w * DW));
                            item.idx  = 2'(c);
                            item.last = (c == hi) && (w == WPC - 1);
                            item.err  = 1'b0;
                            exp_q.push_back(item);
                        end
                    end
`ifdef STATS_CLEAR_ON_READ_EN
                    exp_clear <= 1'b1;
`endif
                end else begin
                    exp_q.push_back(word_t'{data: '0, idx: 2'd0, last: 1'b1, err: 1'b1});
                end
            end
        end
    end

    // Log of words actually transferred by the DUT.
    always @(posedge clk) begin
        if (reset_n && rsp_valid && rsp_ready) begin
            got_q.push_back(word_t'{data: rsp_data, idx: rsp_idx, last: rsp_last, err: rsp_err});
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic [DW+7:0] act_v;
            logic [DW+7:0] exp_v;
            word_t f;
            act_v = {req_ready, busy, rsp_valid, rsp_data, rsp_idx, rsp_last, rsp_err, stats_clear};
            if (exp_q.size() != 0) begin
                f = exp_q[0];
                exp_v = {1'b0, 1'b1, 1'b1, f.data, f.idx, f.last, f.err, exp_clear};
            end else begin
                exp_v = {1'b1, 1'b0, 1'b0, {DW{1'b0}}, 2'd0, 1'b0, 1'b0, exp_clear};
            end
            check("cycle", 128'(act_v), 128'(exp_v));
        end
    end

    task automatic do_req(input logic [2:0] sel);
        int n;
        n = 0;
        req_sel   = sel;
        req_valid = 1'b1;
        while (!req_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_accept_timeout", 128'(n < 50), 128'(1));
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        check("idle_timeout", 128'(busy), 128'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] all_d   [8];
        logic [1:0]    all_idx [8];
        int n;

        reset_n   = 1'b0;
        req_valid = 1'b1;
        req_sel   = 3'd4;
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) ctr[i] = 64'd0;

        // Reset hold with a pending request
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk_en = 1'b1;
            check("rst_req_ready", 128'(req_ready), 128'(1));
            check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
            check("rst_busy", 128'(busy), 128'(0));
        end
        req_valid = 1'b0;
        reset_n   = 1'b1;
        @(posedge clk); #1;

        // Single counter read
        ctr[1] = 64'h0000_0005_0000_0010;
        got_q.delete();
        do_req(3'd1);
        wait_idle();
        check("single_count", 128'(got_q.size()), 128'(2));
        check("single_w0_data", 128'(got_q[0].data), 128'(32'h10));
        check("single_w0_idx", 128'(got_q[0].idx), 128'(1));
        check("single_w0_last", 128'(got_q[0].last), 128'(0));
        check("single_w1_data", 128'(got_q[1].data), 128'(32'h5));
        check("single_w1_last", 128'(got_q[1].last), 128'(1));

        // Dump all counters
        ctr[0] = 64'h11; ctr[1] = 64'h22; ctr[2] = 64'h33; ctr[3] = 64'h44;
        all_d   = '{32'h11, 32'h0, 32'h22, 32'h0, 32'h33, 32'h0, 32'h44, 32'h0};
        all_idx = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        got_q.delete();
        do_req(3'd4);
        wait_idle();
        check("all_count", 128'(got_q.size()), 128'(8));
        for (int i = 0; i < 8; i++) begin
            check("all_data", 128'(got_q[i].data), 128'(all_d[i]));
            check("all_idx", 128'(got_q[i].idx), 128'(all_idx[i]));
            check("all_last", 128'(got_q[i].last), 128'(i == 7));
        end

        // Snapshot isolation under backpressure
        ctr[2]    = 64'd100;
        rsp_ready = 1'b0;
        got_q.delete();
        do_req(3'd2);
        for (int i = 0; i < 5; i++) begin
            check("iso_valid", 128'(rsp_valid), 128'(1));
            check("iso_data", 128'(rsp_data), 128'(100));
            ctr[2] = ctr[2] + 64'd1;
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("iso_count", 128'(got_q.size()), 128'(2));
        check("iso_w0_data", 128'(got_q[0].data), 128'(100));
        check("iso_w1_data", 128'(got_q[1].data), 128'(0));

        // Illegal selector, then a legal read
        got_q.delete();
        do_req(3'd6);
        wait_idle();
        check("err_count", 128'(got_q.size()), 128'(1));
        check("err_flag", 128'(got_q[0].err), 128'(1));
        check("err_last", 128'(got_q[0].last), 128'(1));
        check("err_data", 128'(got_q[0].data), 128'(0));
        check("err_idx", 128'(got_q[0].idx), 128'(0));
        ctr[0] = 64'h0000_0003_0000_0009;
        got_q.delete();
        do_req(3'd0);
        wait_idle();
        check("post_err_count", 128'(got_q.size()), 128'(2));
        check("post_err_w0", 128'(got_q[0].data), 128'(32'h9));
        check("post_err_w1", 128'(got_q[1].data), 128'(32'h3));

        // Reset after the third word of a dump-all
        got_q.delete();
        do_req(3'd4);
        n = 0;
        while (got_q.size() < 3 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("midrst_words_seen", 128'(got_q.size()), 128'(3));
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("midrst_busy", 128'(busy), 128'(0));
        check("midrst_req_ready", 128'(req_ready), 128'(1));
        reset_n = 1'b1;
        @(posedge clk); #1;

        ctr[3] = 64'hCAFE_0001_BEEF_0002;
        got_q.delete();
        do_req(3'd3);
        wait_idle();
        check("post_rst_count", 128'(got_q.size()), 128'(2));
        check("post_rst_w0", 128'(got_q[0].data), 128'(32'hBEEF_0002));
        check("post_rst_w1", 128'(got_q[1].data), 128'(32'hCAFE_0001));
        check("post_rst_idx", 128'(got_q[1].idx), 128'(3));

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/global_stats_reader.md
Name: global_stats_reader

Overview:
Read-side of the global statistics counters (insn-fetch waits, cycles used, operand-fetch waits, vector-local divergences). On a request it snapshots all four 64-bit counters in one cycle. It then streams the selected counter(s) out as DATA_W-bit words over a valid/ready response channel. Sits between the stats counters and the debug/host readout path.

Parameters:
DATA_W, 32, response word width; legal values 16, 32, 64 (must divide 64)
WORDS_PER_CTR, 64/DATA_W, derived; words per counter, not overridable

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
wait_for_insn_fetch  in  64  counter 0
num_cycles_used  in  64  counter 1
wait_for_operand_fetch  in  64  counter 2
num_vector_local_divergences  in  64  counter 3
req_valid  in  1  read request
req_ready  out  1  request accepted when req_valid && req_ready
req_sel  in  3  0..3 = single counter, 4 = all counters in order 0..3, 5..7 = illegal
rsp_valid  out  1  response word valid
rsp_ready  in  1  consumer ready
rsp_data  out  DATA_W  response word, low word first
rsp_idx  out  2  counter index of current word
rsp_last  out  1  final word of response
rsp_err  out  1  set on the single word returned for an illegal req_sel
busy  out  1  high in every state except IDLE
stats_clear  out  1  only with STATS_CLEAR_ON_READ_EN (see below)

Behaviour:
- One clock: clk. Reset: reset_n, synchronous, active-low.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_idx=0, rsp_last=0, rsp_err=0, busy=0, stats_clear=0, FSM=IDLE, snapshot regs=0.
- FSM states: IDLE, SEND, ERR.
- IDLE: req_ready=1. On accept with req_sel<=4: capture all four counters into snapshot regs on the same edge; go to SEND. Set cur_idx = req_sel (0 when req_sel=4) and word=0.
- IDLE, accept with req_sel>=5: go to ERR. Snapshot is not updated.
- SEND: req_ready=0. rsp_valid=1 from the first cycle after accept, so latency is accept edge +1 cycle.
  - rsp_data = snapshot[cur_idx][word*DATA_W +: DATA_W].
  - On handshake (rsp_valid && rsp_ready): advance word. On word wrap, advance cur_idx if mode=all.
  - rsp_last=1 on the final word (last word of the single counter, or last word of counter 3 in all mode).
  - Handshake on the last word: return to IDLE; req_ready=1 in the next cycle.
- ERR: rsp_valid=1, rsp_err=1, rsp_last=1, rsp_data=0, rsp_idx=0. After handshake, return to IDLE.
- Backpressure: while rsp_valid && !rsp_ready, rsp_data, rsp_idx, rsp_last and rsp_err hold stable.
- Snapshot isolation: counter input changes after the accept edge never appear in the response.
- Simultaneous req_valid during SEND/ERR: ignored. Requester must hold req_valid until req_ready.
- Back-to-back: a new request is accepted no earlier than the cycle after the last handshake. No bubble-free overlap.
- Reset mid-response: the response is dropped immediately; all outputs return to their reset values on the next edge.
- Word count: single = WORDS_PER_CTR; all = 4*WORDS_PER_CTR.

Optional Feature:
STATS_CLEAR_ON_READ_EN
- Defined:
  - stats_clear pulses high for exactly 1 cycle, in the cycle after the accept edge of a legal request.
  - The counter owner zeroes all counters on that pulse, so counts between reads are deltas.
  - The snapshot still holds the pre-clear values.
- Undefined: stats_clear is tied to 0. Counters are never cleared by the reader.

Test Plan:
- Reset hold: reset_n=0 for 3 cycles with req_valid=1 -> req_ready=1, rsp_valid=0, busy=0 throughout; no accept.
- Single read, DATA_W=32: counter1=0x0000_0005_0000_0010, req_sel=1, rsp_ready=1 -> exactly 2 words: 0x00000010 (rsp_idx=1, last=0), then 0x00000005 (last=1).
- Dump all with counters 0x11,0x22,0x33,0x44 -> 8 words in order 0x11,0,0x22,0,0x33,0,0x44,0; rsp_idx sequence 0,0,1,1,2,2,3,3; last only on the 8th word.
- Snapshot isolation plus backpressure:
  - Stimulus: counter2=100 at accept, incremented every cycle afterwards; rsp_ready=0 for 5 cycles.
  - Response: rsp_data stays 100 and is stable for all 5 cycles; total words=2.
- Illegal req_sel=6 -> one word: rsp_err=1, rsp_last=1, rsp_data=0; FSM back to IDLE; the next legal request works.
- Mid-response reset: reset_n=0 after word 3 of a dump-all -> next cycle rsp_valid=0 and busy=0. With STATS_CLEAR_ON_READ_EN: stats_clear is one 1-cycle pulse per legal accept and 0 for the illegal request.
